// File: rtl/mult_seq_ctrl.sv
// Multi-cycle WIDTHxWIDTH -> 2*WIDTH multiply sequencer (MULT/MULTU into HI/LO).
// All arithmetic is done on one external WIDTH-bit adder driven through add_a/add_b;
// the sequencer only steers operands and captures add_sum into its registers.
// add_a/add_b are combinational because the adder result is consumed in the same cycle.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_MUL    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;     // holds the multiplier until MUL shifts it out
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;   // final product must be negated
    logic               bneg_q, bneg_d; // multiplier needs negating before MUL
    logic               cz_q, cz_d;     // low word negated to zero: carry into high word
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mul_carry;

    // Adder carry-out: the sum wrapped below its A operand.
    assign mul_carry = (add_sum < hi_q);

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bneg_q  <= 1'b0;
            cz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            bneg_q  <= bneg_d;
            cz_q    <= cz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, adder operand steering and register updates.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bneg_d  = bneg_q;
        cz_d    = cz_q;
        add_a   = '0;
        add_b   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    neg_d   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    bneg_d  = signed_op & op_b[WIDTH-1];
                    if (signed_op && op_a[WIDTH-1]) begin
                        state_d = S_NEG_A;
                    end else if (signed_op && op_b[WIDTH-1]) begin
                        state_d = S_NEG_B;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end

            S_NEG_A: begin
                add_a   = ~mcand_q;
                add_b   = WIDTH'(1);
                mcand_d = add_sum;
                state_d = bneg_q ? S_NEG_B : S_MUL;
            end

            S_NEG_B: begin
                add_a   = ~lo_q;
                add_b   = WIDTH'(1);
                lo_d    = add_sum;
                state_d = S_MUL;
            end

            // One shift-add step per cycle; the 33-bit sum shifts right into {hi,lo}.
            S_MUL: begin
                add_a          = hi_q;
                add_b          = lo_q[0] ? mcand_q : '0;
                {hi_d, lo_d}   = {mul_carry, add_sum, lo_q[WIDTH-1:1]};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = neg_q ? S_NEG_LO : S_DONE;
                end
            end

            S_NEG_LO: begin
                add_a   = ~lo_q;
                add_b   = WIDTH'(1);
                lo_d    = add_sum;
                cz_d    = (add_sum == '0);
                state_d = S_NEG_HI;
            end

            S_NEG_HI: begin
                add_a   = ~hi_q;
                add_b   = WIDTH'(cz_q);
                hi_d    = add_sum;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the upcoming state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

endmodule
